dmem_responder: RTL and testbench
=================================

Name: dmem_responder

Overview:
- Memory-side responder for the pipeline's load/store requests. It is the far end of the MEM-stage interface.
- It accepts one request at a time over a valid/ready handshake and performs the access after a fixed, parameterised latency.
- Store data is written byte-granular. Load data is returned sign- or zero-extended per funct3.
- It sits between the MEM stage and the data memory array, and replaces the single-cycle ideal memory.

Parameters:
- DATA_WIDTH, 32: data word width; the only supported value is 32.
- DATA_MEM_DEPTH, 1024: number of 32-bit words in the array.
- DATA_MEM_ADDR_WIDTH, $clog2(DATA_MEM_DEPTH): word-index width.
- LATENCY, 2: cycles from request acceptance to resp_valid_o; legal range is 1..15.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid_i  in  1  request present.
- req_ready_o  out  1  responder can accept a request.
- req_we_i  in  1  1 = store, 0 = load.
- req_funct3_i  in  3  access size/sign, using the package FUNCT3_LB/LH/LW/LBU/LHU/LWU/SB/SH/SW encodings.
- req_addr_i  in  32  byte address.
- req_wdata_i  in  32  store data, right-aligned (byte/half in the low bits).
- resp_valid_o  out  1  response present.
- resp_ready_i  in  1  consumer accepts the response.
- resp_rdata_o  out  32  extended load data; 0 for stores and for errors.
- resp_err_o  out  1  misaligned access or illegal funct3.

Behaviour:
- Reset:
  - While rst is high: state is IDLE, latency counter is 0, req_ready_o=0, resp_valid_o=0, resp_rdata_o=0, resp_err_o=0.
  - Memory contents are not reset.
  - A reset mid-operation aborts the operation. A store not yet performed is never written. Any pending response is dropped.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - req_ready_o = 1 (combinational: state==IDLE && !rst).
  - On req_valid_i && req_ready_o, latch we/funct3/addr/wdata, load counter with LATENCY-1, and go to WAIT.
  - If LATENCY==1, go directly to the access step.
- WAIT:
  - req_ready_o=0. Decrement the counter each cycle.
  - When the counter is 0, perform the access on that edge and go to RESP.
- Latency:
  - Request accepted on the edge ending cycle N gives resp_valid_o high from cycle N+LATENCY.
  - A store's write to the array is visible to a load accepted after the store's response handshake.
- Access step:
  - Word index = addr[DATA_MEM_ADDR_WIDTH+1:2]. Upper address bits are ignored, so out-of-range addresses wrap.
  - Byte lane = addr[1:0].
  - SB: write wdata[7:0] to the lane addr[1:0].
  - SH: write wdata[15:0] to lanes {addr[1],0}+1..0.
  - SW: write the full word.
  - LB/LH: sign-extend the selected byte/half.
  - LBU/LHU: zero-extend the selected byte/half.
  - LW, and LWU (RV32 treats it as LW): return the full word.
- Errors (resp_err_o=1, rdata=0, no array write):
  - Halfword with addr[0]=1.
  - Word with addr[1:0]!=0.
  - Load funct3 3'b011 or 3'b111.
  - Store funct3 > 3'b010.
- RESP:
  - resp_valid_o, resp_rdata_o and resp_err_o are registered and held stable until resp_ready_i.
  - On the handshake, go to IDLE. The outputs clear to 0 on that edge.
  - req_ready_o rises in the following cycle, so a new request is never accepted in the response-handshake cycle.
- Stability:
  - req_* inputs are sampled only at acceptance. Changes while in WAIT or RESP have no effect.
  - req_valid_i high in WAIT or RESP is simply not accepted; there is no drop and no error.

Decomposition:
- Add to the shared defines package:
  - typedef enum logic [1:0] {MEM_IDLE, MEM_WAIT, MEM_RESP} mem_state_e.
  - MEM_LATENCY_MAX = 15.
- The existing FUNCT3 load/store constants are reused.
- Natural sub-module: dmem_load_ext. It is purely combinational: it takes the word, addr[1:0] and funct3, and produces the extended rdata and a misalign/illegal flag. The top block instances it.

Test Plan:
- Reset, then SW addr 0x10 data 0xDEADBEEF with LATENCY=2 -> req accepted in cycle N; resp_valid_o in cycle N+2; rdata=0, err=0. A following LW 0x10 returns 0xDEADBEEF.
- After that store, LB 0x13 -> 0xFFFFFFDE; LBU 0x13 -> 0x000000DE; LH 0x12 -> 0xFFFFDEAD; LHU 0x10 -> 0x0000BEEF.
- SB 0x11 data 0x55, then LW 0x10 -> 0xDEAD55EF. Then SH 0x12 data 0x1234, then LW 0x10 -> 0x123455EF.
- LW 0x02, SH 0x01, and load funct3 3'b011 -> each gives err=1, rdata=0. A follow-up LW 0x00 shows memory unchanged.
- Hold resp_ready_i=0 for 5 cycles -> resp_valid_o and rdata stay stable and req_ready_o stays 0. Release -> req_ready_o=1 exactly one cycle after the handshake.
- Assert rst in the WAIT cycle of SW 0x20 data 0xA5A5A5A5 -> all outputs are 0 during reset. A subsequent LW 0x20 returns the old value, proving no write occurred. LW 0x1020 (with DEPTH=1024) aliases to word 0x20.

Source files
------------

// File: rtl/dmem_responder_pkg.sv
// Shared definitions for the data-memory responder: FSM states, latency bound,
// RV32 load/store funct3 encodings and the alignment/byte-enable helpers.
package dmem_responder_pkg;

  typedef enum logic [1:0] {MEM_IDLE, MEM_WAIT, MEM_RESP} mem_state_e;

  localparam int MEM_LATENCY_MAX = 15;

  localparam logic [2:0] FUNCT3_LB  = 3'b000;
  localparam logic [2:0] FUNCT3_LH  = 3'b001;
  localparam logic [2:0] FUNCT3_LW  = 3'b010;
  localparam logic [2:0] FUNCT3_LBU = 3'b100;
  localparam logic [2:0] FUNCT3_LHU = 3'b101;
  localparam logic [2:0] FUNCT3_LWU = 3'b110;
  localparam logic [2:0] FUNCT3_SB  = 3'b000;
  localparam logic [2:0] FUNCT3_SH  = 3'b001;
  localparam logic [2:0] FUNCT3_SW  = 3'b010;

  // funct3[1:0] encodes the access size for both loads and stores.
  function automatic logic is_misaligned(input logic [2:0] funct3, input logic [1:0] addr_lo);
    case (funct3[1:0])
      2'b01:   return addr_lo[0];
      2'b10:   return addr_lo != 2'b00;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [3:0] store_be(input logic [2:0] funct3, input logic [1:0] addr_lo);
    case (funct3)
      FUNCT3_SB: return 4'b0001 << addr_lo;
      FUNCT3_SH: return addr_lo[1] ? 4'b1100 : 4'b0011;
      FUNCT3_SW: return 4'b1111;
      default:   return 4'b0000;
    endcase
  endfunction

endpackage

// File: rtl/dmem_load_ext.sv
// Load lane selection and sign/zero extension; flags misaligned or illegal loads.
module dmem_load_ext
  import dmem_responder_pkg::*;
(
  input  logic [31:0] i_word,
  input  logic [1:0]  i_addr_lo,
  input  logic [2:0]  i_funct3,
  output logic [31:0] o_rdata,
  output logic        o_err
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
  always_comb begin
    w_byte  = i_word[{i_addr_lo, 3'b000} +: 8];
    w_half  = i_addr_lo[1] ? i_word[31:16] : i_word[15:0];
    o_err   = is_misaligned(i_funct3, i_addr_lo) | (i_funct3[1:0] == 2'b11);
    o_rdata = '0;
    if (!o_err) begin
      case (i_funct3)
        FUNCT3_LB:             o_rdata = {{24{w_byte[7]}}, w_byte};
        FUNCT3_LH:             o_rdata = {{16{w_half[15]}}, w_half};
        FUNCT3_LW, FUNCT3_LWU: o_rdata = i_word;
        FUNCT3_LBU:            o_rdata = {24'd0, w_byte};
        FUNCT3_LHU:            o_rdata = {16'd0, w_half};
        default:               o_rdata = '0;
      endcase
    end
  end

endmodule

// File: rtl/dmem_responder.sv
// Memory-side responder for MEM-stage load/store requests: one request at a time,
// fixed LATENCY cycles to a registered response, byte-granular stores.
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int DATA_WIDTH          = 32,
  parameter int DATA_MEM_DEPTH      = 1024,
  parameter int DATA_MEM_ADDR_WIDTH = $clog2(DATA_MEM_DEPTH),
  parameter int LATENCY             = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic                  req_we_i,
  input  logic [2:0]            req_funct3_i,
  input  logic [31:0]           req_addr_i,
  input  logic [DATA_WIDTH-1:0] req_wdata_i,
  output logic                  resp_valid_o,
  input  logic                  resp_ready_i,
  output logic [DATA_WIDTH-1:0] resp_rdata_o,
  output logic                  resp_err_o
);

  localparam int AW = DATA_MEM_ADDR_WIDTH;

  mem_state_e r_state, w_state_next;
  logic [3:0]  r_cnt;
  logic        r_we;
  logic [2:0]  r_funct3;
  logic [AW+1:0] r_addr;
  logic [31:0] r_wdata;
  logic        r_resp_valid, r_resp_err;
  logic [31:0] r_resp_rdata;
  logic [31:0] r_mem [DATA_MEM_DEPTH];

  logic          w_accept, w_do_access, w_mem_we;
  logic          w_acc_we, w_ld_err, w_st_err;
  logic [2:0]    w_acc_funct3;
  logic [AW+1:0] w_acc_addr;
  logic [31:0]   w_acc_wdata, w_word, w_ld_rdata, w_st_data;
  logic [AW-1:0] w_idx;
  logic [3:0]    w_be;
  logic          w_unused_addr;

  assign w_unused_addr = ^req_addr_i[31:AW+2];

  always_comb begin
    w_state_next = r_state;
    w_accept     = 1'b0;
    w_do_access  = 1'b0;
    case (r_state)
      MEM_IDLE: if (req_valid_i) begin
        w_accept = 1'b1;
        if (LATENCY == 1) begin
          w_do_access  = 1'b1;
          w_state_next = MEM_RESP;
        end else begin
          w_state_next = MEM_WAIT;
        end
      end
      // The access happens on the edge that takes the counter to zero.
      MEM_WAIT: if (r_cnt == 4'd1) begin
        w_do_access  = 1'b1;
        w_state_next = MEM_RESP;
      end
      MEM_RESP: if (resp_ready_i) w_state_next = MEM_IDLE;
      default:  w_state_next = MEM_IDLE;
    endcase
  end

  // With LATENCY==1 the access uses the request as presented; otherwise the latched copy.
  assign w_acc_we     = (r_state == MEM_IDLE) ? req_we_i               : r_we;
  assign w_acc_funct3 = (r_state == MEM_IDLE) ? req_funct3_i           : r_funct3;
  assign w_acc_addr   = (r_state == MEM_IDLE) ? req_addr_i[AW+1:0]     : r_addr;
  assign w_acc_wdata  = (r_state == MEM_IDLE) ? req_wdata_i            : r_wdata;

  assign w_idx    = w_acc_addr[AW+1:2];
  assign w_word   = r_mem[w_idx];
  assign w_st_err = is_misaligned(w_acc_funct3, w_acc_addr[1:0]) | w_acc_funct3[2]
                  | (w_acc_funct3[1:0] == 2'b11);
  assign w_be     = store_be(w_acc_funct3, w_acc_addr[1:0]);
  assign w_mem_we = w_do_access && !rst && w_acc_we && !w_st_err;

  always_comb begin
    case (w_acc_funct3[1:0])
      2'b00:   w_st_data = {4{w_acc_wdata[7:0]}};
      2'b01:   w_st_data = {2{w_acc_wdata[15:0]}};
      default: w_st_data = w_acc_wdata;
    endcase
  end

  dmem_load_ext u_load_ext (
    .i_word    (w_word),
    .i_addr_lo (w_acc_addr[1:0]),
    .i_funct3  (w_acc_funct3),
    .o_rdata   (w_ld_rdata),
    .o_err     (w_ld_err)
  );

  // NOTE: the array has no reset branch so it maps onto RAM; contents survive rst.
  always_ff @(posedge clk) begin
    if (w_mem_we) begin
      for (int b = 0; b < 4; b++) begin
        if (w_be[b]) r_mem[w_idx][8*b +: 8] <= w_st_data[8*b +: 8];
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= MEM_IDLE;
      r_cnt        <= '0;
      r_resp_valid <= 1'b0;
      r_resp_err   <= 1'b0;
      r_resp_rdata <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_accept) begin
        r_we     <= req_we_i;
        r_funct3 <= req_funct3_i;
        r_addr   <= req_addr_i[AW+1:0];
        r_wdata  <= req_wdata_i;
        r_cnt    <= 4'(LATENCY - 1);
      end else if (r_state == MEM_WAIT) begin
        r_cnt <= r_cnt - 4'd1;
      end
      if (w_do_access) begin
        r_resp_valid <= 1'b1;
        r_resp_err   <= w_acc_we ? w_st_err : w_ld_err;
        r_resp_rdata <= w_acc_we ? 32'd0 : w_ld_rdata;
      end else if (r_state == MEM_RESP && resp_ready_i) begin
        r_resp_valid <= 1'b0;
        r_resp_err   <= 1'b0;
        r_resp_rdata <= '0;
      end
    end
  end

  assign req_ready_o  = (r_state == MEM_IDLE) && !rst;
  assign resp_valid_o = r_resp_valid;
  assign resp_rdata_o = r_resp_rdata;
  assign resp_err_o   = r_resp_err;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed self-checking bench for dmem_responder with LATENCY=2, DEPTH=1024.
module tb_dmem_responder;
  import dmem_responder_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [2:0]  req_funct3 = 3'b000;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        resp_valid;
  logic        resp_ready = 1'b0;
  logic [31:0] resp_rdata;
  logic        resp_err;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  dmem_responder #(
    .DATA_WIDTH(32), .DATA_MEM_DEPTH(1024), .LATENCY(2)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid_i  (req_valid),
    .req_ready_o  (req_ready),
    .req_we_i     (req_we),
    .req_funct3_i (req_funct3),
    .req_addr_i   (req_addr),
    .req_wdata_i  (req_wdata),
    .resp_valid_o (resp_valid),
    .resp_ready_i (resp_ready),
    .resp_rdata_o (resp_rdata),
    .resp_err_o   (resp_err)
  );

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_checks++;
    assert (observed === expected)
    else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, ".req_ready"},  32'(req_ready),  32'd0);
    check({tag, ".resp_valid"}, 32'(resp_valid), 32'd0);
    check({tag, ".resp_rdata"}, resp_rdata,      32'd0);
    check({tag, ".resp_err"},   32'(resp_err),   32'd0);
  endtask

  // Presents a request from a negedge and returns #1 after the accepting edge.
  task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wdata);
    int t = 0;
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wdata;
    while (!req_ready && t < 20) begin
      @(negedge clk);
      t++;
    end
    check("accept_wait", 32'(req_ready), 32'd1);
    @(posedge clk);
    #1;
    // Scramble the request lines to show they are sampled only at acceptance.
    req_valid = 1'b1; req_we = ~we; req_funct3 = 3'b011; req_addr = ~addr; req_wdata = ~wdata;
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  // Returns at the negedge of the first cycle with resp_valid high; lat counts cycles after acceptance.
  task automatic wait_resp(output int lat);
    lat = 1;
    while (!resp_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic txn(input string tag, input logic we, input logic [2:0] f3,
                     input logic [31:0] addr, input logic [31:0] wdata,
                     input logic [31:0] exp_rdata, input logic exp_err);
    int lat;
    issue(we, f3, addr, wdata);
    wait_resp(lat);
    check({tag, ".latency"}, 32'(lat), 32'd2);
    check({tag, ".rdata"},   resp_rdata, exp_rdata);
    check({tag, ".err"},     32'(resp_err), 32'(exp_err));
    resp_ready = 1'b1;
    @(posedge clk);
    #1;
    resp_ready = 1'b0;
    check({tag, ".ready_after"}, 32'(req_ready), 32'd1);
  endtask

  initial begin
    int lat;

    // Reset state
    repeat (2) @(negedge clk);
    check_idle_outputs("reset");
    rst = 1'b0;
    #1;
    check("post_reset_ready", 32'(req_ready), 32'd1);

    // Store then read back, then sub-word loads of the same word
    txn("sw_10",  1'b1, FUNCT3_SW,  32'h10, 32'hDEADBEEF, 32'h0,        1'b0);
    txn("lw_10",  1'b0, FUNCT3_LW,  32'h10, 32'h0,        32'hDEADBEEF, 1'b0);
    txn("lb_13",  1'b0, FUNCT3_LB,  32'h13, 32'h0,        32'hFFFFFFDE, 1'b0);
    txn("lbu_13", 1'b0, FUNCT3_LBU, 32'h13, 32'h0,        32'h000000DE, 1'b0);
    txn("lh_12",  1'b0, FUNCT3_LH,  32'h12, 32'h0,        32'hFFFFDEAD, 1'b0);
    txn("lhu_10", 1'b0, FUNCT3_LHU, 32'h10, 32'h0,        32'h0000BEEF, 1'b0);
    txn("lwu_10", 1'b0, FUNCT3_LWU, 32'h10, 32'h0,        32'hDEADBEEF, 1'b0);

    // Byte and halfword stores merge into the existing word
    txn("sb_11",    1'b1, FUNCT3_SB, 32'h11, 32'h00000055, 32'h0,        1'b0);
    txn("lw_10_sb", 1'b0, FUNCT3_LW, 32'h10, 32'h0,        32'hDEAD55EF, 1'b0);
    txn("sh_12",    1'b1, FUNCT3_SH, 32'h12, 32'h00001234, 32'h0,        1'b0);
    txn("lw_10_sh", 1'b0, FUNCT3_LW, 32'h10, 32'h0,        32'h123455EF, 1'b0);

    // Error cases around word 0; none of them may disturb it
    txn("sw_00",      1'b1, FUNCT3_SW, 32'h00, 32'h0BADF00D, 32'h0,        1'b0);
    txn("lw_02_mis",  1'b0, FUNCT3_LW, 32'h02, 32'h0,        32'h0,        1'b1);
    txn("sh_01_mis",  1'b1, FUNCT3_SH, 32'h01, 32'hFFFFFFFF, 32'h0,        1'b1);
    txn("ld_f3_011",  1'b0, 3'b011,    32'h00, 32'h0,        32'h0,        1'b1);
    txn("st_f3_100",  1'b1, 3'b100,    32'h00, 32'hFFFFFFFF, 32'h0,        1'b1);
    txn("lw_00_kept", 1'b0, FUNCT3_LW, 32'h00, 32'h0,        32'h0BADF00D, 1'b0);

    // Response back-pressure: outputs hold while resp_ready_i stays low
    issue(1'b0, FUNCT3_LW, 32'h10, 32'h0);
    wait_resp(lat);
    check("bp.latency", 32'(lat), 32'd2);
    for (int i = 0; i < 5; i++) begin
      check($sformatf("bp.valid%0d", i), 32'(resp_valid), 32'd1);
      check($sformatf("bp.rdata%0d", i), resp_rdata,      32'h123455EF);
      check($sformatf("bp.ready%0d", i), 32'(req_ready),  32'd0);
      @(negedge clk);
    end
    resp_ready = 1'b1;
    #1;
    check("bp.ready_in_hs", 32'(req_ready), 32'd0);
    @(posedge clk);
    #1;
    resp_ready = 1'b0;
    check("bp.ready_after", 32'(req_ready),  32'd1);
    check("bp.valid_clear", 32'(resp_valid), 32'd0);

    // Reset during WAIT aborts a store
    txn("sw_20_old", 1'b1, FUNCT3_SW, 32'h20, 32'h11112222, 32'h0, 1'b0);
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = FUNCT3_SW;
    req_addr = 32'h20; req_wdata = 32'hA5A5A5A5;
    check("rst_wait.accept", 32'(req_ready), 32'd1);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    check("rst_wait.in_wait", 32'(req_ready), 32'd0);
    rst = 1'b1;
    #1;
    check_idle_outputs("rst_wait.r0");
    @(negedge clk);
    check_idle_outputs("rst_wait.r1");
    @(negedge clk);
    check_idle_outputs("rst_wait.r2");
    rst = 1'b0;
    txn("lw_20_old",   1'b0, FUNCT3_LW, 32'h20,   32'h0,        32'h11112222, 1'b0);
    txn("lw_1020_alias", 1'b0, FUNCT3_LW, 32'h1020, 32'h0,      32'h11112222, 1'b0);
    txn("sw_1024_alias", 1'b1, FUNCT3_SW, 32'h1024, 32'hCAFEF00D, 32'h0,      1'b0);
    txn("lw_24_alias",   1'b0, FUNCT3_LW, 32'h24,   32'h0,      32'hCAFEF00D, 1'b0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed no completion expected finish before 200000");
    $fatal(1, "watchdog expired");
  end

endmodule
